// File: rtl/pwm_pkg.sv
// Shared types and reset constants for the multi-channel PWM generator.
package pwm_pkg;

    typedef enum logic {
        PWM_MODE_EDGE   = 1'b0,
        PWM_MODE_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } pwm_dir_e;

    localparam pwm_mode_e MODE_RESET = PWM_MODE_EDGE;
    // The period resets to all ones at whatever WIDTH the generator is built with.
    localparam logic PERIOD_RESET_FILL = 1'b1;

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: shadow duty written by software, active duty reloaded on load,
// and a registered compare against the shared counter.
module pwm_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             load,
    input  logic [WIDTH-1:0] cnt,
    input  logic             en,
    output logic             pwm_out
);

    logic [WIDTH-1:0] duty_shadow;
    logic [WIDTH-1:0] duty_active;

    // NOTE: sequential state uses <= so every register samples pre-edge values;
    // that is what makes the active reg pick up the old shadow when a write lands
    // on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            duty_shadow <= '0;
            duty_active <= '0;
            pwm_out     <= 1'b0;
        end else begin
            if (wr) begin
                duty_shadow <= wr_data;
            end
            if (load) begin
                duty_active <= duty_shadow;
            end
            pwm_out <= en && (cnt < duty_active);
        end
    end

endmodule

// File: rtl/pwm_multi_generator.sv
// Shared period counter (edge or centre aligned) driving CHANNELS double-buffered
// PWM comparators, with programmable period and a registered period_tick.
module pwm_multi_generator
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                cfg_wr,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic                cfg_mode,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    pwm_dir_e         dir;
    pwm_dir_e         dir_next;
    logic [WIDTH-1:0] period_shadow;
    logic [WIDTH-1:0] period_active;
    pwm_mode_e        mode_shadow;
    pwm_mode_e        mode_active;
    logic             boundary;
    logic             after_boundary;
    logic             load;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        boundary = 1'b0;
        if (en) begin
            if (period_active == '0) begin
                boundary = 1'b1;
            end else if (mode_active == PWM_MODE_EDGE) begin
                boundary = (cnt == period_active);
            end else begin
                boundary = (dir == DIR_DOWN) && (cnt == '0);
            end
        end
    end

    // After a boundary the counter follows the rule of the newly loaded mode.
    always_comb begin
        cnt_next = '0;
        dir_next = DIR_DOWN;
        if (en) begin
            if (boundary) begin
                if (mode_shadow == PWM_MODE_CENTER) begin
                    dir_next = DIR_UP;
                    cnt_next = (period_shadow == '0) ? '0 : WIDTH'(1);
                end
            end else if (mode_active == PWM_MODE_EDGE) begin
                cnt_next = cnt + WIDTH'(1);
            end else if (dir == DIR_UP && cnt != period_active) begin
                dir_next = DIR_UP;
                cnt_next = cnt + WIDTH'(1);
            end else begin
                cnt_next = cnt - WIDTH'(1);
            end
        end
    end

    assign load = boundary || !en;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt            <= '0;
            dir            <= DIR_DOWN;
            period_shadow  <= {WIDTH{PERIOD_RESET_FILL}};
            period_active  <= {WIDTH{PERIOD_RESET_FILL}};
            mode_shadow    <= MODE_RESET;
            mode_active    <= MODE_RESET;
            after_boundary <= 1'b0;
            period_tick    <= 1'b0;
        end else begin
            if (cfg_wr) begin
                period_shadow <= cfg_period;
                mode_shadow   <= pwm_mode_e'(cfg_mode);
            end
            if (load) begin
                period_active <= period_shadow;
                mode_active   <= mode_shadow;
            end
            cnt            <= cnt_next;
            dir            <= dir_next;
            after_boundary <= boundary;
            period_tick    <= en && after_boundary;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_channel (
            .clk     (clk),
            .reset_n (reset_n),
            .wr      (wr_en && (wr_ch == CH_W'(i))),
            .wr_data (wr_data),
            .load    (load),
            .cnt     (cnt),
            .en      (en),
            .pwm_out (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi_generator.sv
// Directed plus randomized bench for pwm_multi_generator, checked cycle by cycle
// against a phase-based model of the period.
module tb_pwm_multi_generator;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk;
    logic          reset_n;
    logic          en;
    logic          wr_en;
    logic [CW-1:0] wr_ch;
    logic [W-1:0]  wr_data;
    logic          cfg_wr;
    logic [W-1:0]  cfg_period;
    logic          cfg_mode;
    logic [CH-1:0] pwm_out;
    logic          period_tick;

    pwm_multi_generator #(
        .CHANNELS(CH),
        .WIDTH   (W),
        .CH_W    (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_data    (wr_data),
        .cfg_wr     (cfg_wr),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
        .pwm_out    (pwm_out),
        .period_tick(period_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: position k inside a period of length L; cnt derived from k.
    int            m_dsh [CH];
    int            m_dact[CH];
    int            m_ps, m_pa, m_k;
    logic          m_ms, m_ma, m_prevb, m_tick;
    logic [CH-1:0] m_out;

    function automatic int plen(int p, logic m);
        if (p == 0) return 1;
        return m ? 2 * p : p + 1;
    endfunction

    function automatic int cnt_of(int k, int p, logic m);
        if (!m) return k;
        if (p == 0) return 0;
        return (k < p) ? k + 1 : 2 * p - 1 - k;
    endfunction

    function automatic int m_cnt();
        return cnt_of(m_k, m_pa, m_ma);
    endfunction

    task automatic model_edge();
        int   c;
        logic b;
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) begin
                m_dsh[i]  = 0;
                m_dact[i] = 0;
            end
            m_ps = 255; m_pa = 255; m_ms = 1'b0; m_ma = 1'b0;
            m_k = 0; m_prevb = 1'b0; m_out = '0; m_tick = 1'b0;
            return;
        end
        c = m_cnt();
        b = en && (m_k == plen(m_pa, m_ma) - 1);
        for (int i = 0; i < CH; i++) m_out[i] = en && (c < m_dact[i]);
        m_tick  = en && m_prevb;
        m_prevb = b;
        if (!en || b) begin
            for (int i = 0; i < CH; i++) m_dact[i] = m_dsh[i];
            m_pa = m_ps;
            m_ma = m_ms;
            m_k  = (!en && m_ms) ? plen(m_ps, m_ms) - 1 : 0;
        end else begin
            m_k = m_k + 1;
        end
        if (wr_en && wr_ch < CW'(CH)) m_dsh[wr_ch] = wr_data;
        if (cfg_wr) begin
            m_ps = cfg_period;
            m_ms = cfg_mode;
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            check("pwm_out", 32'(pwm_out), 32'(m_out));
            check("period_tick", 32'(period_tick), 32'(m_tick));
        end
    endtask

    task automatic wr(int ch, int d);
        wr_en = 1'b1; wr_ch = CW'(ch); wr_data = W'(d);
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic cfg(int p, logic m);
        cfg_wr = 1'b1; cfg_period = W'(p); cfg_mode = m;
        step(1);
        cfg_wr = 1'b0;
    endtask

    task automatic wait_cnt(int target, string tag);
        int guard = 0;
        while (m_cnt() != target && guard < 600) begin
            step(1);
            guard++;
        end
        check(tag, 32'(m_cnt() == target), 32'd1);
    endtask

    task automatic window(int n, int ch, output int hi, output int tk);
        hi = 0; tk = 0;
        repeat (n) begin
            step(1);
            hi += int'(pwm_out[ch]);
            tk += int'(period_tick);
        end
    endtask

    initial begin
        int hi, tk, hi1, hi2;
        reset_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
        cfg_wr = 1'b0; cfg_period = '0; cfg_mode = 1'b0;
        step(2);
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_tick", 32'(period_tick), 32'd0);
        reset_n = 1'b1;
        step(1);

        // Edge mode, P=9: duties 3, 0, 10.
        cfg(9, 1'b0); wr(0, 3); wr(1, 0); wr(2, 10);
        en = 1'b1;
        step(25);
        window(10, 0, hi, tk);
        check("edge_ch0_high", 32'(hi), 32'd3);
        check("edge_tick_count", 32'(tk), 32'd1);
        window(10, 1, hi1, tk);
        check("edge_ch1_high", 32'(hi1), 32'd0);
        window(10, 2, hi2, tk);
        check("edge_ch2_high", 32'(hi2), 32'd10);

        // Mid-period duty write, then a write on the boundary cycle.
        wait_cnt(2, "reach_cnt2");
        wr(0, 7);
        step(30);
        window(10, 0, hi, tk);
        check("edge_new_duty", 32'(hi), 32'd7);
        wait_cnt(9, "reach_cnt9");
        wr(0, 3);
        step(30);

        // Centre mode, P=4, duty 2.
        cfg(4, 1'b1); wr(0, 2);
        step(30);
        window(8, 0, hi, tk);
        check("centre_high", 32'(hi), 32'd3);
        check("centre_tick_count", 32'(tk), 32'd1);

        // P=0 in both modes, then back to a full 256-cycle edge period.
        cfg(0, 1'b0); wr(0, 1);
        step(15);
        cfg(0, 1'b1);
        step(5);
        window(5, 0, hi, tk);
        check("p0_high", 32'(hi), 32'd5);
        check("p0_ticks", 32'(tk), 32'd5);
        cfg(255, 1'b0); wr(0, 255);
        step(300);
        window(256, 0, hi, tk);
        check("full_period_high", 32'(hi), 32'd255);
        check("full_period_ticks", 32'(tk), 32'd1);

        // Reset in the middle of a pulse.
        cfg(9, 1'b0); wr(0, 5);
        en = 1'b0; step(1); en = 1'b1;
        step(25);
        wait_cnt(2, "reach_cnt2_rst");
        reset_n = 1'b0;
        step(1);
        check("midreset_pwm", 32'(pwm_out), 32'd0);
        check("midreset_tick", 32'(period_tick), 32'd0);
        reset_n = 1'b1;
        window(20, 0, hi, tk);
        check("post_reset_low", 32'(hi), 32'd0);

        // Illegal index, enable drop, re-enable in both modes.
        en = 1'b0; cfg(9, 1'b0); wr(0, 4); wr(1, 6);
        en = 1'b1;
        step(20);
        wr(5, 9);
        step(20);
        en = 1'b0;
        step(3);
        check("disabled_pwm", 32'(pwm_out), 32'd0);
        en = 1'b1;
        step(12);
        cfg(3, 1'b1);
        en = 1'b0;
        step(2);
        en = 1'b1;
        step(1);
        check("centre_reenable_tick0", 32'(period_tick), 32'd0);
        step(1);
        check("centre_reenable_tick1", 32'(period_tick), 32'd1);
        step(20);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            reset_n    = ($urandom_range(0, 299) != 0);
            en         = ($urandom_range(0, 19) != 0);
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_ch      = CW'($urandom_range(0, 7));
            wr_data    = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 14));
            cfg_wr     = ($urandom_range(0, 24) == 0);
            cfg_period = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
            cfg_mode   = 1'($urandom_range(0, 1));
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_multi_generator.md
Name: pwm_multi_generator

Overview:
Multi-channel, parametrised successor to the single-channel 8-bit PWM generator. One shared period counter drives CHANNELS comparators. Each channel has a double-buffered duty register: software writes a shadow register, and the active register loads only at a period boundary, so outputs never glitch. Adds a programmable period and a centre-aligned (up/down) mode. Sits on the processor's MMIO side, driving motor and LED outputs.

Parameters:
CHANNELS, 4, number of PWM outputs (1..16)
WIDTH, 8, counter, duty and period width in bits
CH_W, $clog2(CHANNELS) (minimum 1), width of the channel index

Ports:
clk  in  1  system clock; all logic on its rising edge
reset_n  in  1  synchronous, active-low reset
en  in  1  global enable
wr_en  in  1  duty write strobe
wr_ch  in  CH_W  channel index for the duty write
wr_data  in  WIDTH  duty value
cfg_wr  in  1  period/mode write strobe
cfg_period  in  WIDTH  period value P
cfg_mode  in  1  0 = edge-aligned, 1 = centre-aligned
pwm_out  out  CHANNELS  registered PWM outputs
period_tick  out  1  one-cycle pulse marking the start of each output period

Behaviour:
- Reset (reset_n=0 at a clk edge): cnt=0, dir=down, all shadow and active duties=0, period shadow and active=2^WIDTH-1, mode=edge, pwm_out=0, period_tick=0. Applies mid-period; no partial pulse completes.
- Writes: wr_en loads shadow[wr_ch] at the next edge. wr_ch>=CHANNELS is ignored. cfg_wr loads the period and mode shadows. Writes are accepted whether en is high or low.
- en=0: cnt held at 0, dir held at down, active regs <= shadow regs every cycle, pwm_out=0, period_tick=0.
- Boundary cycle (B): at the edge ending B, every active reg <= its shadow, and active P and mode <= their shadows.
  - A write in the same cycle as B lands in the shadow only and takes effect at the following boundary. There is no bypass.
- Edge mode:
  - cnt counts 0..P, then wraps to 0; period = P+1 cycles.
  - B is the cycle with cnt==P.
- Centre mode:
  - Up phase: cnt<P gives cnt+1. cnt==P gives cnt-1 and dir<=down.
  - Down phase: cnt>0 gives cnt-1. cnt==0 gives B; then cnt<=1 (or 0 if the new P==0) and dir<=up.
  - Period = 2P cycles.
  - Because dir is held at down while en=0, the first enabled cycle is a boundary in centre mode. In edge mode the first boundary comes P+1 cycles after enable.
- P==0 in either mode: cnt stays 0, every cycle is B, and each output is high iff duty>0.
- Output: pwm_out[i] <= en & (cnt < active_duty[i]), an unsigned WIDTH-bit compare.
  - Latency is 1 cycle from cnt to pwm_out.
  - duty=0 gives constant low. duty>P gives constant high in edge mode.
  - With P=2^WIDTH-1 and duty=2^WIDTH-1, the output is high 255 of 256 cycles (WIDTH=8).
- period_tick: registered. High for exactly the one cycle in which pwm_out shows the first sample of a new period (the cycle after cnt's first post-boundary value). This covers both modes and every cycle when P==0.
- A mode change at a boundary: the next cnt follows the new mode's rule (edge gives 0; centre gives 1, or 0 if the new P==0).

Decomposition:
- Package pwm_pkg:
  - PWM_MODE_EDGE=1'b0 and PWM_MODE_CENTER=1'b1
  - reset constants for P and mode
- Sub-module pwm_channel, instantiated CHANNELS times:
  - contains the shadow reg, active reg and registered compare
  - inputs: clk, reset_n, wr, wr_data, load (boundary or !en), cnt, en
  - output: pwm_out
- Top level holds the counter, dir, period/mode shadow-and-active registers, boundary detection and period_tick.

Test Plan:
- Edge mode, P=9, ch0 duty=3, ch1 duty=0, ch2 duty=10, en=1 -> ch0 repeats 3 high / 7 low; ch1 always 0; ch2 always 1; period_tick every 10 cycles, coincident with ch0's rising edge.
- Edge mode, P=9, ch0 duty=3; write duty=7 at cnt=2 -> current period stays at 3 high; next period is 7 high / 3 low. Repeat the write with the wr_en cycle coinciding with cnt==9 -> the change appears one period later.
- Centre mode, P=4, ch0 duty=2 -> cnt sequence 0,1,2,3,4,3,2,1 repeats; pwm_out is high 3 of 8 cycles, contiguous around cnt==0; period_tick every 8 cycles.
- P=0 (both modes), duty=1 -> output constantly high and period_tick high every cycle. Then cfg_wr with P=255 and mode=edge -> 256-cycle periods begin after the next boundary.
- Reset mid-pulse (edge, P=9, duty=5, reset_n=0 at cnt=2) -> next cycle pwm_out=0 and period_tick=0. Shadows return to 0, so outputs stay low after reset_n=1 until new writes.
- en toggle and illegal index (CHANNELS=4): write wr_ch=5 -> no channel changes. Drop en for 3 cycles -> outputs 0. Raise en -> in centre mode period_tick fires on the second enabled cycle; in edge mode a fresh period starts with cnt=0.
